core_imem_port: RTL and testbench
=================================

// Module: core_imem_port
// PURPOSE
//  Instruction-memory responder for the S1 fetch stage. Accepts one fetch request (word address)
//  from core_s1 and issues it on the imem bus. Returns the fetched instruction, or a fault, to S1.
//  Sits between core_s1 and the imem/bus fabric. Handles flushes from branches/traps with
//  requests in flight. At most one request is outstanding at any time.
// PARAMETERS
//  TIMEOUT_CYCLES  255           WAIT cycles before a bus timeout fault; 0 = timeout disabled
//  FAULT_INSTR     32'h00000013  instr value returned with any fault (NOP)
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   reset, asynchronous, active-low
//  s1_flush            in   1   branch/trap redirect; kills current request
//  s1_req_valid        in   1   S1 fetch request
//  s1_req_ready        out  1   port can accept a request (combinational: state==IDLE)
//  s1_req_addr         in   32  fetch address (word_t)
//  s1_rsp_valid        out  1   response valid; held until accepted
//  s1_rsp_ready        in   1   S1 accepts response
//  s1_rsp_instr        out  32  fetched instruction
//  s1_rsp_fault        out  1   bus error or timeout
//  s1_rsp_misaligned   out  1   address misaligned (see CONFIGURATION)
//  bus_req_valid       out  1   bus read request
//  bus_req_ready       in   1   bus accepts request
//  bus_req_addr        out  32  word-aligned read address {addr[31:2],2'b00}
//  bus_rsp_valid       in   1   bus read data valid (1-cycle pulse; no backpressure)
//  bus_rsp_data        in   32  read data
//  bus_rsp_err         in   1   bus error with response
// BEHAVIOUR
//  Reset values: state=IDLE, s1_rsp_valid=0, bus_req_valid=0, s1_rsp_fault=0,
//   s1_rsp_misaligned=0, s1_rsp_instr=FAULT_INSTR, kill=0, timeout counter=0.
//   s1_req_ready=1 (IDLE).
//  IDLE:  On s1_req_valid & ~s1_flush: latch addr, go to ISSUE. On s1_req_valid & s1_flush:
//         drop the request.
//  ISSUE: bus_req_valid=1, registered. Stays asserted until bus_req_ready (never retracted).
//         A flush here sets kill. On accept: go to DRAIN if kill is set, else go to WAIT.
//  WAIT:  Counter increments each cycle.
//         On bus_rsp_valid: capture data and err, go to RESP.
//         A flush here goes to DRAIN.
//         When counter==TIMEOUT_CYCLES (nonzero): fault=1, instr=FAULT_INSTR, set pend_drain,
//         go to RESP.
//  RESP:  s1_rsp_valid=1, with instr/fault/misaligned stable. On s1_rsp_ready or s1_flush:
//         go to DRAIN if pend_drain is set, else go to IDLE. A flush discards an unaccepted
//         response.
//  DRAIN: Wait for the stale bus_rsp_valid, discard it, clear kill/pend_drain, go to IDLE.
//         No timeout here.
//  Latency: req accepted at cycle N -> bus_req_valid at N+1. Bus rsp at cycle M ->
//   s1_rsp_valid at M+1. Best case 3 cycles request-to-response.
//  Data on a bus error: fault=1, instr=FAULT_INSTR (bus data is ignored).
//  Simultaneous events:
//   - flush with bus_rsp_valid in WAIT: flush wins; response discarded; go to IDLE
//     (no DRAIN needed).
//   - timeout and bus_rsp_valid in the same cycle: response wins; no fault.
//  Counter: TIMEOUT_CYCLES is 16 bits wide max. Clears on entry to WAIT; saturates (no wrap).
//  Reset mid-operation: immediately returns to IDLE. Any outstanding bus rsp after reset is
//   ignored in IDLE.
// CONFIGURATION
//  LETC_IMEM_MISALIGN_CHECK_EN defined:
//   - IDLE with s1_req_addr[1:0]!=0 -> RESP directly, with no bus request.
//   - Response carries misaligned=1, fault=0, instr=FAULT_INSTR.
//  LETC_IMEM_MISALIGN_CHECK_EN undefined:
//   - addr[1:0] is ignored and the aligned word is fetched.
//   - s1_rsp_misaligned is tied to 0.
// TESTING
//  Normal fetch:
//   - stimulus: req 0x0000_1000; bus_req_ready same cycle; rsp data 0x00500093 two cycles
//     later; s1_rsp_ready=1.
//   - expect: bus_req_addr=0x1000; s1_rsp_instr=0x00500093, fault=0; back in IDLE.
//  Backpressure:
//   - stimulus: bus_req_ready low for 5 cycles, then s1_rsp_ready low for 3 cycles.
//   - expect: bus_req_valid held for 6 cycles; s1_rsp_valid held for 4 cycles with stable data.
//  Flush in WAIT:
//   - stimulus: req 0x2000 accepted; flush; next req 0x3000; stale rsp 0xDEADBEEF arrives.
//   - expect: stale rsp dropped in DRAIN; the 0x3000 data is the only response to S1.
//  Bus error:
//   - stimulus: bus_rsp_err=1 with data 0x12345678.
//   - expect: fault=1, instr=0x00000013.
//  Timeout:
//   - stimulus: TIMEOUT_CYCLES=4; bus never responds.
//   - expect: fault response at the 4th WAIT cycle; DRAIN until a late rsp arrives, then IDLE.
//  Misaligned (with LETC_IMEM_MISALIGN_CHECK_EN):
//   - stimulus: req 0x1002.
//   - expect: no bus_req_valid; misaligned=1 response next cycle.
//   Without the macro: bus_req_addr=0x1000.

Source files
------------

// File: rtl/core_imem_port_if.sv
// rtl/core_imem_port_if.sv - S1 fetch and imem bus handshake signals for core_imem_port
interface core_imem_port_if;
    logic        s1_flush;
    logic        s1_req_valid;
    logic        s1_req_ready;
    logic [31:0] s1_req_addr;
    logic        s1_rsp_valid;
    logic        s1_rsp_ready;
    logic [31:0] s1_rsp_instr;
    logic        s1_rsp_fault;
    logic        s1_rsp_misaligned;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_data;
    logic        bus_rsp_err;

    modport slave (
        input  s1_flush, s1_req_valid, s1_req_addr, s1_rsp_ready,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err,
        output s1_req_ready, s1_rsp_valid, s1_rsp_instr, s1_rsp_fault, s1_rsp_misaligned,
        output bus_req_valid, bus_req_addr
    );

    modport master (
        output s1_flush, s1_req_valid, s1_req_addr, s1_rsp_ready,
        output bus_req_ready, bus_rsp_valid, bus_rsp_data, bus_rsp_err,
        input  s1_req_ready, s1_rsp_valid, s1_rsp_instr, s1_rsp_fault, s1_rsp_misaligned,
        input  bus_req_valid, bus_req_addr
    );
endinterface

// File: rtl/core_imem_port.sv
// rtl/core_imem_port.sv - single-outstanding imem fetch responder for S1 (option: LETC_IMEM_MISALIGN_CHECK_EN)
module core_imem_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] FAULT_INSTR    = 32'h00000013
) (
    input logic              clk,
    input logic              rst_n,
    core_imem_port_if.slave  imem
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

    logic [2:0]  state;
    logic        kill;
    logic        pend_drain;
    logic [15:0] wait_cnt;
    logic        rsp_valid_q;
    logic [31:0] rsp_instr_q;
    logic        rsp_fault_q;
    logic        rsp_mis_q;
    logic        bus_req_valid_q;
    logic [31:0] bus_req_addr_q;
    logic        req_misaligned;
    logic [16:0] cnt_inc;
    logic        timeout_hit;

`ifdef LETC_IMEM_MISALIGN_CHECK_EN
    assign req_misaligned = (imem.s1_req_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^imem.s1_req_addr[1:0];
    assign req_misaligned   = 1'b0;
`endif

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle, so the fault lands right after it.
    assign cnt_inc     = {1'b0, wait_cnt} + 17'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LIM);

    assign imem.s1_req_ready      = (state == S_IDLE);
    assign imem.s1_rsp_valid      = rsp_valid_q;
    assign imem.s1_rsp_instr      = rsp_instr_q;
    assign imem.s1_rsp_fault      = rsp_fault_q;
    assign imem.s1_rsp_misaligned = rsp_mis_q;
    assign imem.bus_req_valid     = bus_req_valid_q;
    assign imem.bus_req_addr      = bus_req_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            kill            <= 1'b0;
            pend_drain      <= 1'b0;
            wait_cnt        <= 16'd0;
            rsp_valid_q     <= 1'b0;
            rsp_instr_q     <= FAULT_INSTR;
            rsp_fault_q     <= 1'b0;
            rsp_mis_q       <= 1'b0;
            bus_req_valid_q <= 1'b0;
            bus_req_addr_q  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (imem.s1_req_valid && !imem.s1_flush) begin
                        bus_req_addr_q <= {imem.s1_req_addr[31:2], 2'b00};
                        if (req_misaligned) begin
                            rsp_valid_q <= 1'b1;
                            rsp_instr_q <= FAULT_INSTR;
                            rsp_fault_q <= 1'b0;
                            rsp_mis_q   <= 1'b1;
                            state       <= S_RESP;
                        end else begin
                            bus_req_valid_q <= 1'b1;
                            state           <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (imem.s1_flush) begin
                        kill <= 1'b1;
                    end
                    // Request is never retracted; a killed one still owes us a response.
                    if (imem.bus_req_ready) begin
                        bus_req_valid_q <= 1'b0;
                        wait_cnt        <= 16'd0;
                        state           <= (kill || imem.s1_flush) ? S_DRAIN : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                    if (imem.s1_flush) begin
                        state <= imem.bus_rsp_valid ? S_IDLE : S_DRAIN;
                    end else if (imem.bus_rsp_valid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_instr_q <= imem.bus_rsp_err ? FAULT_INSTR : imem.bus_rsp_data;
                        rsp_fault_q <= imem.bus_rsp_err;
                        rsp_mis_q   <= 1'b0;
                        state       <= S_RESP;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_instr_q <= FAULT_INSTR;
                        rsp_fault_q <= 1'b1;
                        rsp_mis_q   <= 1'b0;
                        pend_drain  <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (imem.s1_rsp_ready || imem.s1_flush) begin
                        rsp_valid_q <= 1'b0;
                        state       <= pend_drain ? S_DRAIN : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (imem.bus_rsp_valid) begin
                        kill       <= 1'b0;
                        pend_drain <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_imem_port.sv
// tb/tb_core_imem_port.sv - directed vector bench for core_imem_port
module tb_core_imem_port;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_imem_port_if imem();

    core_imem_port #(.TIMEOUT_CYCLES(4), .FAULT_INSTR(NOP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .imem (imem)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          bus_wait;
        int          rsp_lat;
        logic [31:0] data;
        logic        err;
        int          rsp_hold;
        logic [31:0] exp_instr;
        logic        exp_fault;
        logic [31:0] exp_baddr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input vec_t v, input string tag);
        int          n;
        logic [31:0] first_instr;
        logic        first_fault;
        logic        stable;
        chk({tag, "/req_ready"}, 32'(imem.s1_req_ready), 32'd1);
        imem.s1_req_valid = 1'b1;
        imem.s1_req_addr  = v.addr;
        step();
        imem.s1_req_valid = 1'b0;
        chk({tag, "/bus_req_valid"}, 32'(imem.bus_req_valid), 32'd1);
        chk({tag, "/bus_req_addr"}, imem.bus_req_addr, v.exp_baddr);
        n = 0;
        while (imem.bus_req_valid && n < 50) begin
            imem.bus_req_ready = (n >= v.bus_wait);
            step();
            n++;
        end
        imem.bus_req_ready = 1'b0;
        chk({tag, "/bus_req_hold"}, n, v.bus_wait + 1);
        repeat (v.rsp_lat) step();
        imem.bus_rsp_valid = 1'b1;
        imem.bus_rsp_data  = v.data;
        imem.bus_rsp_err   = v.err;
        step();
        imem.bus_rsp_valid = 1'b0;
        imem.bus_rsp_err   = 1'b0;
        chk({tag, "/rsp_valid"}, 32'(imem.s1_rsp_valid), 32'd1);
        chk({tag, "/rsp_instr"}, imem.s1_rsp_instr, v.exp_instr);
        chk({tag, "/rsp_fault"}, 32'(imem.s1_rsp_fault), 32'(v.exp_fault));
        chk({tag, "/rsp_mis"}, 32'(imem.s1_rsp_misaligned), 32'd0);
        first_instr = imem.s1_rsp_instr;
        first_fault = imem.s1_rsp_fault;
        stable = 1'b1;
        n = 0;
        while (imem.s1_rsp_valid && n < 50) begin
            if (imem.s1_rsp_instr !== first_instr || imem.s1_rsp_fault !== first_fault)
                stable = 1'b0;
            imem.s1_rsp_ready = (n >= v.rsp_hold);
            step();
            n++;
        end
        imem.s1_rsp_ready = 1'b0;
        chk({tag, "/rsp_hold"}, n, v.rsp_hold + 1);
        chk({tag, "/rsp_stable"}, 32'(stable), 32'd1);
        chk({tag, "/idle_after"}, 32'(imem.s1_req_ready), 32'd1);
    endtask

    // Issue a request and get it accepted by the bus at once; returns in the first WAIT cycle.
    task automatic start_req(input logic [31:0] addr);
        imem.s1_req_valid = 1'b1;
        imem.s1_req_addr  = addr;
        step();
        imem.s1_req_valid  = 1'b0;
        imem.bus_req_ready = 1'b1;
        step();
        imem.bus_req_ready = 1'b0;
    endtask

    task automatic bus_pulse(input logic [31:0] data);
        imem.bus_rsp_valid = 1'b1;
        imem.bus_rsp_data  = data;
        step();
        imem.bus_rsp_valid = 1'b0;
    endtask

    initial begin
        int   n;
        int   seen;
        vec_t mv;

        imem.s1_flush      = 1'b0;
        imem.s1_req_valid  = 1'b0;
        imem.s1_req_addr   = 32'd0;
        imem.s1_rsp_ready  = 1'b0;
        imem.bus_req_ready = 1'b0;
        imem.bus_rsp_valid = 1'b0;
        imem.bus_rsp_data  = 32'd0;
        imem.bus_rsp_err   = 1'b0;

        vecs[0] = '{32'h0000_1000, 0, 1, 32'h0050_0093, 1'b0, 0, 32'h0050_0093, 1'b0, 32'h0000_1000};
        vecs[1] = '{32'h0000_1004, 5, 0, 32'hAAAA_5555, 1'b0, 3, 32'hAAAA_5555, 1'b0, 32'h0000_1004};
        vecs[2] = '{32'h0000_2008, 0, 2, 32'h1234_5678, 1'b1, 0, NOP,           1'b1, 32'h0000_2008};
        vecs[3] = '{32'hFFFF_FFFC, 2, 0, 32'hFFFF_FFFF, 1'b0, 1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC};
        vecs[4] = '{32'h0000_3000, 0, 3, 32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0, 32'h0000_3000};
        vecs[5] = '{32'h0000_400C, 1, 2, 32'h0000_0000, 1'b1, 2, NOP,           1'b1, 32'h0000_400C};

        repeat (2) @(posedge clk);
        #1;
        chk("reset/req_ready", 32'(imem.s1_req_ready), 32'd1);
        chk("reset/rsp_valid", 32'(imem.s1_rsp_valid), 32'd0);
        chk("reset/bus_req_valid", 32'(imem.bus_req_valid), 32'd0);
        chk("reset/rsp_fault", 32'(imem.s1_rsp_fault), 32'd0);
        chk("reset/rsp_mis", 32'(imem.s1_rsp_misaligned), 32'd0);
        chk("reset/rsp_instr", imem.s1_rsp_instr, NOP);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush alongside a request in IDLE drops it.
        imem.s1_req_valid = 1'b1;
        imem.s1_req_addr  = 32'h0000_5000;
        imem.s1_flush     = 1'b1;
        step();
        imem.s1_req_valid = 1'b0;
        imem.s1_flush     = 1'b0;
        chk("idle_flush/bus_req_valid", 32'(imem.bus_req_valid), 32'd0);
        chk("idle_flush/req_ready", 32'(imem.s1_req_ready), 32'd1);

        // Flush in WAIT: stale response must be swallowed by DRAIN.
        start_req(32'h0000_2000);
        imem.s1_flush = 1'b1;
        step();
        imem.s1_flush = 1'b0;
        chk("wait_flush/drain_blocks", 32'(imem.s1_req_ready), 32'd0);
        imem.s1_req_valid = 1'b1;
        imem.s1_req_addr  = 32'h0000_3000;
        seen = 0;
        repeat (3) begin
            step();
            if (imem.s1_rsp_valid) seen++;
        end
        chk("wait_flush/still_drain", 32'(imem.s1_req_ready), 32'd0);
        imem.s1_req_valid = 1'b0;
        bus_pulse(32'hDEAD_BEEF);
        if (imem.s1_rsp_valid) seen++;
        chk("wait_flush/no_stale_rsp", seen, 0);
        mv = '{32'h0000_3000, 0, 0, 32'h0030_0113, 1'b0, 0, 32'h0030_0113, 1'b0, 32'h0000_3000};
        fetch(mv, "wait_flush/next");

        // Timeout after 4 WAIT cycles, then DRAIN until the late response.
        start_req(32'h0000_6000);
        n = 0;
        while (!imem.s1_rsp_valid && n < 50) begin
            step();
            n++;
        end
        chk("timeout/latency", n, 4);
        chk("timeout/fault", 32'(imem.s1_rsp_fault), 32'd1);
        chk("timeout/instr", imem.s1_rsp_instr, NOP);
        imem.s1_rsp_ready = 1'b1;
        step();
        imem.s1_rsp_ready = 1'b0;
        chk("timeout/rsp_dropped", 32'(imem.s1_rsp_valid), 32'd0);
        repeat (3) step();
        chk("timeout/drain_holds", 32'(imem.s1_req_ready), 32'd0);
        bus_pulse(32'h1111_1111);
        chk("timeout/idle_after", 32'(imem.s1_req_ready), 32'd1);
        chk("timeout/no_late_rsp", 32'(imem.s1_rsp_valid), 32'd0);

        // Flush and bus response together in WAIT: straight back to IDLE.
        start_req(32'h0000_7000);
        imem.s1_flush      = 1'b1;
        imem.bus_rsp_valid = 1'b1;
        imem.bus_rsp_data  = 32'h2222_2222;
        step();
        imem.s1_flush      = 1'b0;
        imem.bus_rsp_valid = 1'b0;
        chk("flush_rsp/idle", 32'(imem.s1_req_ready), 32'd1);
        chk("flush_rsp/no_rsp", 32'(imem.s1_rsp_valid), 32'd0);

        // Flush in ISSUE: request stays up, then DRAIN.
        imem.s1_req_valid = 1'b1;
        imem.s1_req_addr  = 32'h0000_8000;
        step();
        imem.s1_req_valid = 1'b0;
        imem.s1_flush     = 1'b1;
        step();
        imem.s1_flush = 1'b0;
        chk("issue_flush/held", 32'(imem.bus_req_valid), 32'd1);
        imem.bus_req_ready = 1'b1;
        step();
        imem.bus_req_ready = 1'b0;
        chk("issue_flush/accepted", 32'(imem.bus_req_valid), 32'd0);
        chk("issue_flush/drain", 32'(imem.s1_req_ready), 32'd0);
        bus_pulse(32'h3333_3333);
        chk("issue_flush/idle", 32'(imem.s1_req_ready), 32'd1);
        chk("issue_flush/no_rsp", 32'(imem.s1_rsp_valid), 32'd0);

        // Flush discards an unaccepted response.
        start_req(32'h0000_9000);
        bus_pulse(32'h0000_0055);
        chk("resp_flush/valid", 32'(imem.s1_rsp_valid), 32'd1);
        imem.s1_flush = 1'b1;
        step();
        imem.s1_flush = 1'b0;
        chk("resp_flush/dropped", 32'(imem.s1_rsp_valid), 32'd0);
        chk("resp_flush/idle", 32'(imem.s1_req_ready), 32'd1);

`ifdef LETC_IMEM_MISALIGN_CHECK_EN
        imem.s1_req_valid = 1'b1;
        imem.s1_req_addr  = 32'h0000_1002;
        step();
        imem.s1_req_valid = 1'b0;
        chk("misalign/no_bus", 32'(imem.bus_req_valid), 32'd0);
        chk("misalign/rsp_valid", 32'(imem.s1_rsp_valid), 32'd1);
        chk("misalign/mis", 32'(imem.s1_rsp_misaligned), 32'd1);
        chk("misalign/fault", 32'(imem.s1_rsp_fault), 32'd0);
        chk("misalign/instr", imem.s1_rsp_instr, NOP);
        imem.s1_rsp_ready = 1'b1;
        step();
        imem.s1_rsp_ready = 1'b0;
        chk("misalign/idle", 32'(imem.s1_req_ready), 32'd1);
`else
        mv = '{32'h0000_1002, 0, 0, 32'h0010_0073, 1'b0, 0, 32'h0010_0073, 1'b0, 32'h0000_1000};
        fetch(mv, "misalign_off");
`endif

        // Reset mid-operation, then a stray response in IDLE is ignored.
        start_req(32'h0000_A000);
        rst_n = 1'b0;
        #1;
        chk("midreset/idle", 32'(imem.s1_req_ready), 32'd1);
        chk("midreset/bus_req_valid", 32'(imem.bus_req_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        bus_pulse(32'h4444_4444);
        chk("midreset/stray_ignored", 32'(imem.s1_rsp_valid), 32'd0);
        chk("midreset/still_idle", 32'(imem.s1_req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
